// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM array controller.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    ACCESS
  } state_t;

  // Wide enough for PRE_CYC up to 7 (counter loads PRE_CYC-1).
  localparam int PRE_CNT_W = 3;

endpackage

// File: rtl/sram_bitcell_array.sv
// Storage rows with wordline decoder, write port and registered read port.
module sram_bitcell_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              access,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DEPTH-1:0]  wl_oh,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] rows [DEPTH];
  logic [DATA_W-1:0] sensed;

  // Addresses beyond DEPTH decode to no wordline, which drops writes and reads zero.
  always_comb begin
    wl_oh = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (access && (addr == ADDR_W'(i))) begin
        wl_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sensed = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wl_oh[i]) begin
        sensed = sensed | rows[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rows[i] <= '0;
      end
      rdata <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wl_oh[i] && we) begin
          rows[i] <= wdata;
        end
      end
      if (access && !we) begin
        rdata <= sensed;
      end
    end
  end

endmodule

// File: rtl/sram_array_ctrl.sv
// Access controller: request handshake, precharge/access sequencing, read response.
module sram_array_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int PRE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [DEPTH-1:0]  wl_oh,
  output logic              precharge,
  output logic              sense_en,
  output logic              busy
);

  state_t               state, state_nx;
  logic [PRE_CNT_W-1:0] pre_cnt;
  logic                 accept;
  logic                 access;
  logic                 lat_we;
  logic [ADDR_W-1:0]    lat_addr;
  logic [DATA_W-1:0]    lat_wdata;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = PRE;
        end
      end
      PRE: begin
        if (pre_cnt == '0) begin
          state_nx = ACCESS;
        end
      end
      ACCESS:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      rsp_valid <= (state == ACCESS) && !lat_we;
      if (accept) begin
        pre_cnt   <= PRE_CNT_W'(PRE_CYC - 1);
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end else if ((state == PRE) && (pre_cnt != '0)) begin
        pre_cnt <= pre_cnt - 1'b1;
      end
    end
  end

  assign access    = (state == ACCESS);
  assign req_ready = (state == IDLE);
  assign busy      = !req_ready;
  assign precharge = (state == PRE);
  assign sense_en  = access && !lat_we;

  sram_bitcell_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .access (access),
    .we     (lat_we),
    .addr   (lat_addr),
    .wdata  (lat_wdata),
    .wl_oh  (wl_oh),
    .rdata  (rsp_rdata)
  );

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Directed and random checks of two controller instances against a behavioural array model.
module tb_sram_array_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        we;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic        sel;

  logic        a_valid, a_ready, a_rv, a_pre, a_sense, a_busy;
  logic [7:0]  a_rd;
  logic [15:0] a_wl;
  logic        b_valid, b_ready, b_rv, b_pre, b_sense, b_busy;
  logic [7:0]  b_rd;
  logic [11:0] b_wl;

  logic        m_ready, m_rv, m_pre, m_sense, m_busy;
  logic [7:0]  m_rd;
  logic [15:0] m_wl;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mdl [2][16];
  logic [7:0]  last_rd [2];
  time         t_acc;

  assign a_valid = req_valid & ~sel;
  assign b_valid = req_valid & sel;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_rv    = sel ? b_rv    : a_rv;
  assign m_pre   = sel ? b_pre   : a_pre;
  assign m_sense = sel ? b_sense : a_sense;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_rd    = sel ? b_rd    : a_rd;
  assign m_wl    = sel ? {4'b0000, b_wl} : a_wl;

  sram_array_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .PRE_CYC(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .rsp_valid(a_rv), .rsp_rdata(a_rd),
    .wl_oh(a_wl), .precharge(a_pre), .sense_en(a_sense), .busy(a_busy)
  );

  sram_array_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .PRE_CYC(3)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .rsp_valid(b_rv), .rsp_rdata(b_rd),
    .wl_oh(b_wl), .precharge(b_pre), .sense_en(b_sense), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic inv(input string tag, input logic pre, input logic [15:0] wl,
                     input logic ready, input logic bsy, input logic sense);
    checks += 4;
    assert (!(pre && (wl != 16'h0000))) else begin
      errors++; $error("FAIL %s_pre_wl: observed pre=%b wl=%h expected no overlap", tag, pre, wl);
    end
    assert ($onehot0(wl)) else begin
      errors++; $error("FAIL %s_onehot: observed wl=%h expected onehot0", tag, wl);
    end
    assert (bsy === !ready) else begin
      errors++; $error("FAIL %s_busy: observed busy=%b expected %b", tag, bsy, !ready);
    end
    assert (!sense || (!pre && !ready)) else begin
      errors++; $error("FAIL %s_sense: observed sense=1 pre=%b ready=%b expected access phase", tag, pre, ready);
    end
  endtask

  always @(negedge clk) begin
    inv("inv_a", a_pre, a_wl, a_ready, a_busy, a_sense);
    inv("inv_b", b_pre, {4'b0000, b_wl}, b_ready, b_busy, b_sense);
  end

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < 16; r++) mdl[s][r] = 8'h00;
      last_rd[s] = 8'h00;
    end
  endtask

  // One access from request to the response cycle, checking every phase on the way.
  task automatic do_op(input bit s, input bit w, input logic [3:0] ad,
                       input logic [7:0] wd, input bit hold);
    int          p;
    int          d;
    int          n;
    logic [15:0] exp_wl;
    logic [7:0]  exp_rd;
    logic [7:0]  old_rd;
    sel = s;
    p   = s ? 3 : 1;
    d   = s ? 12 : 16;
    #1;
    n = 0;
    while (!m_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", 32'(m_ready), 32'd1);
    req_valid = 1'b1;
    we        = w;
    addr      = ad;
    wdata     = wd;
    @(posedge clk);
    t_acc = $time;
    #1;
    if (!hold) req_valid = 1'b0;

    exp_wl = '0;
    if (int'(ad) < d) exp_wl[ad] = 1'b1;
    old_rd = last_rd[s];
    exp_rd = w ? old_rd : ((int'(ad) < d) ? mdl[s][ad] : 8'h00);
    if (w && int'(ad) < d) mdl[s][ad] = wd;
    if (!w) last_rd[s] = exp_rd;

    for (int k = 0; k < p; k++) begin
      @(negedge clk);
      chk("pre_precharge", 32'(m_pre), 32'd1);
      chk("pre_ready", 32'(m_ready), 32'd0);
      chk("pre_wl", 32'(m_wl), 32'd0);
      chk("pre_sense", 32'(m_sense), 32'd0);
      chk("pre_rsp_valid", 32'(m_rv), 32'd0);
    end
    @(negedge clk);
    chk("acc_precharge", 32'(m_pre), 32'd0);
    chk("acc_ready", 32'(m_ready), 32'd0);
    chk("acc_wl", 32'(m_wl), 32'(exp_wl));
    chk("acc_sense", 32'(m_sense), 32'(!w));
    chk("acc_rsp_valid", 32'(m_rv), 32'd0);
    chk("acc_rdata_hold", 32'(m_rd), 32'(old_rd));
    @(negedge clk);
    chk("rsp_valid", 32'(m_rv), 32'(!w));
    chk("rsp_ready", 32'(m_ready), 32'd1);
    chk("rsp_rdata", 32'(m_rd), 32'(exp_rd));
  endtask

  initial begin
    time prev;
    rst = 1'b1; req_valid = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_ready", 32'(m_ready), 32'd1);
      chk("rst_rsp_valid", 32'(m_rv), 32'd0);
      chk("rst_rdata", 32'(m_rd), 32'd0);
      chk("rst_wl", 32'(m_wl), 32'd0);
      chk("rst_precharge", 32'(m_pre), 32'd0);
      chk("rst_sense", 32'(m_sense), 32'd0);
      chk("rst_busy", 32'(m_busy), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset contents read back as zero, then write/read on the same row.
    do_op(0, 0, 4'd3, 8'h00, 0);
    do_op(0, 1, 4'd5, 8'hA5, 0);
    do_op(0, 0, 4'd5, 8'h00, 0);

    // Long-precharge instance, back-to-back reads with valid held high.
    do_op(1, 1, 4'd7, 8'h5A, 0);
    do_op(1, 1, 4'd8, 8'hC3, 0);
    do_op(1, 0, 4'd7, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      prev = t_acc;
      do_op(1, 0, (i[0] ? 4'd7 : 4'd8), 8'h00, 1);
      chk("accept_period", 32'(t_acc - prev), 32'd50);
    end
    req_valid = 1'b0;

    // Rows beyond DEPTH: write dropped, read returns zero, neighbours untouched.
    do_op(1, 1, 4'd13, 8'hFF, 0);
    do_op(1, 0, 4'd13, 8'h00, 0);
    do_op(1, 0, 4'd1, 8'h00, 0);

    // Reset in the middle of a write aborts it and clears the array.
    do_op(0, 1, 4'd2, 8'h3C, 0);
    sel = 1'b0; req_valid = 1'b1; we = 1'b1; addr = 4'd2; wdata = 8'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_pre", 32'(m_pre), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rsp_valid", 32'(m_rv), 32'd0);
    chk("abort_ready", 32'(m_ready), 32'd1);
    chk("abort_precharge", 32'(m_pre), 32'd0);
    chk("abort_rdata", 32'(m_rd), 32'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(0, 0, 4'd2, 8'h00, 0);
    do_op(1, 0, 4'd7, 8'h00, 0);

    for (int i = 0; i < 2000; i++) begin
      do_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), 8'($urandom), 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_array_ctrl.md
Name: sram_array_ctrl

Overview:
- Parametrised synchronous SRAM macro: a DEPTH x DATA_W array of storage cells plus its access controller.
- Generalises our single differential-bitline cell into an addressable array with per-access precharge, wordline and sense phases.
- Provides a valid/ready request port and a read-response port.
- Sits between the datapath and the cell array; phase strobes are exported so the bench can check cell-level sequencing.

Parameters:
- DATA_W, 8, word width (bits per row).
- ADDR_W, 4, address width.
- DEPTH, 16, number of implemented rows; DEPTH <= 2**ADDR_W.
- PRE_CYC, 1, bitline precharge cycles per access; legal range 1..7.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  row address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  read data valid, one-cycle pulse.
- rsp_rdata  output  DATA_W  read data.
- wl_oh  output  DEPTH  one-hot wordline, observation only.
- precharge  output  1  bitline precharge phase active.
- sense_en  output  1  sense-amp enable (read ACCESS cycle).
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0.
  - wl_oh = 0, precharge = 0, sense_en = 0, busy = 0.
  - All array rows cleared to 0.
  - An in-flight access is aborted: no write commit, no response.
- States: IDLE, PRE, ACCESS.
- IDLE:
  - req_ready = 1.
  - On req_valid at a rising edge: latch we/addr/wdata, load pre_cnt = PRE_CYC-1, go to PRE.
  - Inputs are don't-care outside the accepting IDLE edge.
- PRE:
  - precharge = 1, req_ready = 0, wl_oh = 0.
  - Decrement pre_cnt each cycle; at pre_cnt == 0 go to ACCESS.
  - PRE therefore lasts exactly PRE_CYC cycles.
- ACCESS (exactly 1 cycle):
  - wl_oh = one-hot of the latched address, or all-zero if address >= DEPTH.
  - precharge = 0.
  - Write: row updated at the closing edge.
  - Read: sense_en = 1; row registered into rsp_rdata at the closing edge.
  - Next state IDLE.
- Response:
  - rsp_valid = 1 for exactly the first IDLE cycle after a read ACCESS; never pulses for writes.
  - rsp_rdata holds its last value until the next read completes.
- Latency and throughput:
  - Accepting edge to rsp_valid high is PRE_CYC+1 cycles.
  - A new request may be accepted in the same IDLE cycle that rsp_valid is high.
  - Back-to-back period is PRE_CYC+2 cycles.
- Out-of-range address (>= DEPTH):
  - Write is dropped and the array is unchanged.
  - Read returns 0 with a normal rsp_valid pulse.
  - FSM timing is identical to an in-range access.
- Read-after-write to the same address returns the new data; no bypass is needed because the accesses are serialised.
- Invariants (bench asserts):
  - precharge and any wl_oh bit never high in the same cycle.
  - wl_oh is $onehot0.
  - sense_en is high only in a read ACCESS cycle.
  - busy == !req_ready.

Decomposition:
- Package sram_pkg: state enum (IDLE, PRE, ACCESS) and the PRE_CNT_W = 3 constant.
- One sub-module, sram_bitcell_array, parametrised by DATA_W/ADDR_W/DEPTH:
  - Contains the storage, wordline decoder, write port and registered read port.
  - Has the same async reset clear.
  - Controller owns the FSM, handshake and phase strobes.

Test Plan:
1. Reset then read addr 3 -> rsp_valid pulses 2 cycles after accept (PRE_CYC=1) with rsp_rdata=0x00; precharge high 1 cycle, then wl_oh=16'h0008 with sense_en=1.
2. Write 0xA5 to addr 5, then read addr 5 -> rsp_rdata=0xA5; no rsp_valid during the write; req_ready low for 2 cycles per access.
3. PRE_CYC=3 instance, back-to-back reads held valid -> precharge high 3 cycles, rsp_valid 4 cycles after each accept, accept period 5 cycles.
4. DEPTH=12, write 0xFF to addr 13, then read addr 13 -> wl_oh=0 in both ACCESS cycles, array unchanged, rsp_rdata=0x00.
5. Write 0x3C to addr 2, assert rst during PRE of a write 0x77 to addr 2, release, read addr 2 -> 0x00 (array cleared, aborted write not committed, rsp_valid=0 immediately on reset).
6. Random 2000-op write/read mix vs scoreboard model -> all read data match; all invariants hold every cycle.
